// File: rtl/full_adder.sv
// One-bit full adder, the ripple-chain cell for fa_8. Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa_8.sv
// Registered ripple-carry adder: {Co,S} <= A + B + Ci, one cycle of latency.
module fa_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  // carry[i] feeds stage i; carry[WIDTH] is the final carry-out
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = Ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S  <= '0;
      Co <= 1'b0;
    end else begin
      S  <= sum;
      Co <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_fa_8.sv
// Directed and random checks for fa_8; inputs change on negedge, outputs sampled 1ns after posedge.
module tb_fa_8;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       Ci;
  logic [7:0] S;
  logic       Co;

  int checks;
  int errors;

  fa_8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Ci  (Ci),
    .S   (S),
    .Co  (Co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    Ci  = c;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hA5, 8'h5A, 1'b1);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h000) begin
      errors++;
      $display("FAIL reset: got Co=%0b S=%02h, want Co=0 S=00", Co, S);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 8'h01, 8'hFF, 1'b0);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h100) begin
      errors++;
      $display("FAIL wrap 01+FF+0: got Co=%0b S=%02h, want Co=1 S=00", Co, S);
    end
  endtask

  task automatic test_extremes();
    drive(1'b0, 8'hFF, 8'hFF, 1'b1);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h1FF) begin
      errors++;
      $display("FAIL max FF+FF+1: got Co=%0b S=%02h, want Co=1 S=FF", Co, S);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h000) begin
      errors++;
      $display("FAIL zero 00+00+0: got Co=%0b S=%02h, want Co=0 S=00", Co, S);
    end
  endtask

  task automatic test_ripple();
    drive(1'b0, 8'h7F, 8'h01, 1'b1);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h081) begin
      errors++;
      $display("FAIL ripple 7F+01+1: got Co=%0b S=%02h, want Co=0 S=81", Co, S);
    end
    drive(1'b0, 8'h00, 8'hFF, 1'b1);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h100) begin
      errors++;
      $display("FAIL ripple 00+FF+1: got Co=%0b S=%02h, want Co=1 S=00", Co, S);
    end
    drive(1'b0, 8'h55, 8'hAA, 1'b0);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h0FF) begin
      errors++;
      $display("FAIL 55+AA+0: got Co=%0b S=%02h, want Co=0 S=FF", Co, S);
    end
  endtask

  // Outputs must hold while inputs move between edges
  task automatic test_hold();
    drive(1'b0, 8'h12, 8'h34, 1'b0);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h046) begin
      errors++;
      $display("FAIL hold load 12+34+0: got Co=%0b S=%02h, want Co=0 S=46", Co, S);
    end
    A  = 8'hF0;
    B  = 8'hF0;
    Ci = 1'b1;
    #2;
    checks++;
    if ({Co, S} !== 9'h046) begin
      errors++;
      $display("FAIL hold midcycle: got Co=%0b S=%02h, want Co=0 S=46", Co, S);
    end
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h1E1) begin
      errors++;
      $display("FAIL hold next F0+F0+1: got Co=%0b S=%02h, want Co=1 S=E1", Co, S);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 8'h80, 8'h80, 1'b0);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h100) begin
      errors++;
      $display("FAIL prio preload 80+80+0: got Co=%0b S=%02h, want Co=1 S=00", Co, S);
    end
    drive(1'b1, 8'h10, 8'h20, 1'b1);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h000) begin
      errors++;
      $display("FAIL prio reset: got Co=%0b S=%02h, want Co=0 S=00", Co, S);
    end
    drive(1'b0, 8'h10, 8'h20, 1'b1);
    edge_sample();
    checks++;
    if ({Co, S} !== 9'h031) begin
      errors++;
      $display("FAIL prio release 10+20+1: got Co=%0b S=%02h, want Co=0 S=31", Co, S);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp;
    for (int n = 0; n < 1000; n++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      c   = 1'($urandom_range(0, 1));
      exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
      drive(1'b0, a, b, c);
      edge_sample();
      checks++;
      if ({Co, S} !== exp) begin
        errors++;
        $display("FAIL random #%0d A=%02h B=%02h Ci=%0b: got Co=%0b S=%02h, want Co=%0b S=%02h",
                 n, a, b, c, Co, S, exp[8], exp[7:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    A   = 8'h00;
    B   = 8'h00;
    Ci  = 1'b0;
    test_reset();
    test_wrap();
    test_extremes();
    test_ripple();
    test_hold();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
